// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// 3-sample majority helper.
package uart_pkg;

    localparam int OVS_DEFAULT = 16;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator: one tick every max(baud_div,1) clocks.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // >= rather than == so a divider lowered on the fly cannot strand the count
    assign last = (baud_div == '0) ? '0 : baud_div - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= last) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit recovery with
// per-frame latched format and a valid/ready output holding register.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int OVS    = OVS_DEFAULT,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop_bits,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_error,
    output logic              frame_error,
    output logic              break_det,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    localparam int PH_W = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_A   = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0] PH_B   = PH_W'(OVS / 2);
    localparam logic [PH_W-1:0] PH_C   = PH_W'(OVS / 2 + 1);
    localparam logic [PH_W-1:0] PH_END = PH_W'(OVS - 1);

    logic tick;

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .tick     (tick)
    );

    logic              rx_m, rx_s, rx_prev;
    rx_state_e         state;
    logic [PH_W-1:0]   phase;
    logic [2:0]        samp;
    logic [3:0]        bit_cnt, nbits, nbits_in;
    logic              par_en, par_odd, stop2, stop_idx;
    logic [DATA_W-1:0] shift;
    logic              par_acc, any_one, ferr, perr;
    logic              vote_reg, vote_now, bit_end;
    logic              stop_last, stop_vote, stop_end, ferr_fin, brk_fin;

    assign dbg_state = state;
    assign nbits_in  = (data_bits > 4'(DATA_W)) ? 4'(DATA_W) : data_bits;
    assign vote_reg  = maj3(samp);
    assign vote_now  = maj3({rx_s, samp[1], samp[0]});
    assign bit_end   = tick && (phase == PH_END);

    // The final stop bit is closed right after its third sample so a
    // back-to-back start edge is never missed.
    assign stop_last = (stop_idx == stop2);
    assign stop_vote = stop_last ? vote_now : vote_reg;
    assign stop_end  = tick && (stop_last ? (phase == PH_C) : (phase == PH_END));
    assign ferr_fin  = ferr | ~stop_vote;
    assign brk_fin   = ~(any_one | (~stop_idx & stop_vote));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Output handshake: rx_data and flags are held while rx_valid is high and
    // change only on an edge where rx_valid && rx_ready, or when a completing
    // frame is loaded into an empty/accepting slot in that same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            phase        <= '0;
            samp         <= '0;
            bit_cnt      <= '0;
            nbits        <= '0;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            stop2        <= 1'b0;
            stop_idx     <= 1'b0;
            shift        <= '0;
            par_acc      <= 1'b0;
            any_one      <= 1'b0;
            ferr         <= 1'b0;
            perr         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (tick && state != ST_IDLE && state != ST_WAIT_HIGH) begin
                phase <= (phase == PH_END) ? '0 : phase + 1'b1;
                if (phase == PH_A) samp[0] <= rx_s;
                if (phase == PH_B) samp[1] <= rx_s;
                if (phase == PH_C) samp[2] <= rx_s;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= ST_START;
                        phase    <= '0;
                        nbits    <= nbits_in;
                        par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                        par_odd  <= (parity_mode == PAR_ODD);
                        stop2    <= stop_bits;
                        bit_cnt  <= '0;
                        stop_idx <= 1'b0;
                        shift    <= '0;
                        par_acc  <= 1'b0;
                        any_one  <= 1'b0;
                        ferr     <= 1'b0;
                        perr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end)
                        state <= vote_reg ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift[bit_cnt] <= vote_reg;
                        par_acc        <= par_acc ^ vote_reg;
                        any_one        <= any_one | vote_reg;
                        bit_cnt        <= bit_cnt + 1'b1;
                        if (bit_cnt == nbits - 1'b1)
                            state <= par_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        perr    <= par_acc ^ vote_reg ^ par_odd;
                        any_one <= any_one | vote_reg;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (stop_end) begin
                        if (!stop_last) begin
                            stop_idx <= 1'b1;
                            any_one  <= any_one | stop_vote;
                            ferr     <= ferr_fin;
                        end else begin
                            if (!rx_valid || rx_ready) begin
                                rx_data      <= shift;
                                rx_valid     <= 1'b1;
                                parity_error <= perr;
                                frame_error  <= ferr_fin;
                                break_det    <= brk_fin;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= ferr_fin ? ST_WAIT_HIGH : ST_IDLE;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: vector table of frame formats plus
// hand-written sequences for error recovery, overrun, glitches and reset.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int W = 12;
    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic [15:0] baud_div = 16'd1;
    logic [3:0] data_bits = 4'd8;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_bits = 1'b0;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_error, frame_error, break_det, overrun;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cycles = 0;
    int ovr_cnt = 0;
    logic [W-1:0] exp_q[$];

    uart_rx_cfg dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .baud_div     (baud_div),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .break_det    (break_det),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted transfer is compared against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) valid_cycles++;
            if (overrun) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%0h expected none",
                             {break_det, frame_error, parity_error, rx_data});
                end else begin
                    check("frame", {20'd0, break_det, frame_error, parity_error, rx_data},
                          {20'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic bit_time(input logic v, input int n);
        rx = v;
        repeat (16 * n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                              input logic pbit, input int nstop, input logic s0, input logic s1);
        bit_time(1'b0, 1);
        for (int i = 0; i < nb; i++) bit_time(d[i], 1);
        if (has_par) bit_time(pbit, 1);
        bit_time(s0, 1);
        if (nstop == 2) bit_time(s1, 1);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [3:0] dbits;
        logic [1:0] pmode;
        logic       sbits;
        logic [8:0] data;
        logic       pbit;
        logic       stop0;
        logic       stop1;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        vecs[0] = '{4'd8, 2'b00, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd7, 2'b01, 1'b0, 9'h055, 1'b1, 1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'd7, 2'b01, 1'b0, 9'h055, 1'b0, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd7, 2'b10, 1'b0, 9'h055, 1'b1, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd8, 2'b00, 1'b1, 9'h03C, 1'b0, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'd5, 2'b11, 1'b0, 9'h1F3, 1'b0, 1'b1, 1'b1, 9'h013, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'd9, 2'b10, 1'b0, 9'h1A5, 1'b1, 1'b1, 1'b1, 9'h1A5, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{4'd8, 2'b01, 1'b1, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data", {23'd0, rx_data}, 32'd0);
        check("reset_flags", {28'd0, parity_error, frame_error, break_det, overrun}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, 3'(ST_IDLE)});
        rst = 1'b1;
        bit_time(1'b1, 2);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            data_bits   = vecs[i].dbits;
            parity_mode = vecs[i].pmode;
            stop_bits   = vecs[i].sbits;
            valid_cycles = 0;
            exp_q.push_back({vecs[i].exp_brk, vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_data});
            send_frame(vecs[i].data, int'(vecs[i].dbits),
                       (vecs[i].pmode == 2'b01) || (vecs[i].pmode == 2'b10),
                       vecs[i].pbit, vecs[i].sbits ? 2 : 1, vecs[i].stop0, vecs[i].stop1);
            bit_time(1'b1, 2);
            check($sformatf("vec%0d_received", i), exp_q.size(), 32'd0);
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles, 32'd1);
        end

        // 8N2, second stop low and rx held low: parked in WAIT_HIGH
        data_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 9'h03C});
        send_frame(9'h03C, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        bit_time(1'b0, 3);
        check("ferr_wait_high", {29'd0, dbg_state}, {29'd0, 3'(ST_WAIT_HIGH)});
        bit_time(1'b1, 2);
        check("ferr_back_idle", {29'd0, dbg_state}, {29'd0, 3'(ST_IDLE)});
        check("ferr_received", exp_q.size(), 32'd0);

        // Break: rx low for 12 bit times on 8N1
        stop_bits = 1'b0;
        valid_cycles = 0;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 9'h000});
        bit_time(1'b0, 12);
        check("break_one_frame", valid_cycles, 32'd1);
        check("break_wait_high", {29'd0, dbg_state}, {29'd0, 3'(ST_WAIT_HIGH)});
        bit_time(1'b1, 2);
        check("break_no_restart", valid_cycles, 32'd1);
        check("break_received", exp_q.size(), 32'd0);

        // Overrun: rx_ready low, 0x11 then 0x22
        rx_ready = 1'b0;
        ovr_cnt = 0;
        exp_q.push_back({3'b000, 9'h011});
        send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        bit_time(1'b1, 1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        bit_time(1'b1, 2);
        check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check("ovr_data_kept", {23'd0, rx_data}, 32'h011);
        check("ovr_pulses", ovr_cnt, 32'd1);
        rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("ovr_valid_fall", {31'd0, rx_valid}, 32'd0);
        check("ovr_drained", exp_q.size(), 32'd0);

        // 4-clk glitch, then 0x3C with config scrambled after the start bit
        valid_cycles = 0;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        bit_time(1'b1, 2);
        check("glitch_no_valid", valid_cycles, 32'd0);
        check("glitch_idle", {29'd0, dbg_state}, {29'd0, 3'(ST_IDLE)});
        exp_q.push_back({3'b000, 9'h03C});
        bit_time(1'b0, 1);
        data_bits = 4'd5; parity_mode = 2'b01; stop_bits = 1'b1;
        for (int i = 0; i < 8; i++) bit_time(((9'h03C >> i) & 9'h1) != 9'h0, 1);
        bit_time(1'b1, 1);
        data_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
        bit_time(1'b1, 2);
        check("cfg_hold_received", exp_q.size(), 32'd0);
        check("cfg_hold_valid_cycles", valid_cycles, 32'd1);

        // Reset mid-DATA with a frame pending in the output register
        rx_ready = 1'b0;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        bit_time(1'b1, 1);
        check("rst_pre_valid", {31'd0, rx_valid}, 32'd1);
        bit_time(1'b0, 3);
        rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {23'd0, rx_data}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, 3'(ST_IDLE)});
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        rx_ready = 1'b1;
        valid_cycles = 0;
        bit_time(1'b1, 1);
        exp_q.push_back({3'b000, 9'h0F0});
        send_frame(9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        bit_time(1'b1, 2);
        check("post_rst_received", exp_q.size(), 32'd0);
        check("post_rst_valid_cycles", valid_cycles, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 9, meaning maximum data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVS, default 16, meaning sample ticks per bit; legal values are even numbers 8..32.
REQ-003 SHALL have parameter DIV_W, default 16, meaning width of baud_div.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous, active-low reset.
REQ-005 SHALL have port rx, input, width 1: serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port baud_div, input, width DIV_W: clk cycles per sample tick.
REQ-007 SHALL have port data_bits, input, width 4: data bits per frame, 5..DATA_W.
REQ-008 SHALL have port parity_mode, input, width 2: 00 none, 01 even, 10 odd, 11 none.
REQ-009 SHALL have port stop_bits, input, width 1: 0 selects one stop bit, 1 selects two.
REQ-010 SHALL have ports rx_data (output, DATA_W), rx_valid (output, 1) and rx_ready (input, 1), forming the output handshake.
REQ-011 SHALL have outputs parity_error, frame_error and break_det (each 1 bit): per-frame sideband flags, valid while rx_valid is high.
REQ-012 SHALL have output overrun, width 1: one-cycle pulse when a frame is dropped.

Function
REQ-013 SHALL pass rx through a 2-FF synchroniser; all FSM decisions SHALL use the synchronised value.
REQ-014 SHALL generate one sample tick every max(baud_div,1) clk cycles using a free-running counter, so baud_div=0 behaves as 1.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-016 SHALL move IDLE->START on a synchronised falling edge, clear the tick phase counter, and latch data_bits, parity_mode and stop_bits for the whole frame.
REQ-017 SHALL take each bit value as the majority vote of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1 within the bit.
REQ-018 SHALL return START->IDLE (false start, no output) if the start-bit vote is 1; otherwise it SHALL go to DATA.
REQ-019 SHALL shift data bits in LSB-first in DATA; after data_bits bits it SHALL go to PARITY if parity is enabled, else to STOP.
REQ-020 SHALL set parity_error when the XOR of the data bits and the parity bit is 1 in even mode, or 0 in odd mode.
REQ-021 SHALL check stop_bits+1 stop bits; any stop vote of 0 SHALL set frame_error.
REQ-022 SHALL set break_det when all data bits, the parity bit (if enabled) and the first stop bit are 0; break_det implies frame_error.
REQ-023 SHALL present the completed frame on rx_data the clk cycle after the final stop vote and assert rx_valid in that same cycle; bits above data_bits SHALL be 0.
REQ-024 SHALL hold rx_valid, rx_data and the flags stable until a clk edge with rx_valid&&rx_ready; rx_valid SHALL then fall on that edge unless a new frame completes on the same edge.
REQ-025 SHALL, on simultaneous handshake and new-frame completion, present the new frame with rx_valid kept high.
REQ-026 SHALL, if a frame completes while rx_valid&&!rx_ready, keep the old frame, discard the new one, and pulse overrun for 1 cycle.
REQ-027 SHALL go from STOP to WAIT_HIGH after a frame error and stay there until the synchronised rx is 1; otherwise it SHALL go STOP->IDLE.
REQ-028 SHALL not let config changes mid-frame affect the frame in progress.

Reset
REQ-029 SHALL, while rst=0, set state IDLE, all counters 0, synchroniser flops 1, rx_data 0, and rx_valid, parity_error, frame_error, break_det and overrun all 0.
REQ-030 SHALL abort a frame in progress on reset with no output; after rst deasserts, the first falling edge SHALL start a new frame.

Structure
REQ-031 SHALL take from shared package uart_pkg the parity_mode encodings, the FSM state enum and the OVS default.
REQ-032 SHALL implement the tick generator as sub-module uart_baud_tick (ports clk, rst, baud_div, tick).

Verification
Common setup: OVS=16, baud_div=1, so one bit is 16 clk; rx_ready=1 unless stated.
REQ-033 SHALL cover 8N1 frame 0xA5 -> rx_data=0x0A5, one rx_valid cycle, all flags 0.
REQ-034 SHALL cover 7E1 data 0x55 with parity bit 1 -> rx_data=0x055, parity_error=1; with parity bit 0 -> parity_error=0.
REQ-035 SHALL cover 8N2 with second stop bit 0 -> frame_error=1, then FSM in WAIT_HIGH until rx=1; and rx held low for 12 bit times -> break_det=1, frame_error=1, exactly one frame, no restart until rx=1.
REQ-036 SHALL cover rx_ready=0 with frames 0x11 then 0x22 -> rx_data stays 0x011, one overrun pulse; after rx_ready=1, rx_valid falls.
REQ-037 SHALL cover a 4-clk low glitch on idle rx -> no rx_valid; then a valid 0x3C frame -> 0x03C received.
REQ-038 SHALL cover rst pulsed low mid-DATA -> outputs 0 immediately; the next frame 0xF0 is received correctly.
